cpu_sequencer: RTL and testbench

//  Registered control sequencer for the accumulator CISC core. It owns the

---
 rtl/cpu_sequencer_pkg.sv | 40 ++++
 rtl/cpu_sequencer_wait_timer.sv | 32 +++
 rtl/cpu_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the accumulator CISC control sequencer.
// State codes, 3-bit opcode map and the datapath strobe bundle.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC1  = 3'b010,
    ST_EXEC2  = 3'b011,
    ST_RESET  = 3'b100,
    ST_HALT   = 3'b101
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef struct packed {
    logic ld_ir;
    logic ld_mdr;
    logic ld_acc;
    logic ld_pc;
    logic inc;
    logic sel;
    logic rd;
    logic wr;
    logic dout_en;
  } strobes_t;

  // ADD/AND/XOR/LOAD read an operand in EXEC1 and write ACC in EXEC2.
  function automatic logic is_mem_rd_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Stall counter for memory accesses.
// Ports:
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_stall   current cycle is waiting on memory (access pending, mem_ready=0)
//   o_expire  this stalled cycle is the last one allowed; access is abandoned
// The count clears whenever the access is not stalling (ready or other state),
// and on expiry since the sequencer leaves the state. Saturates at all-ones.
module cpu_sequencer_wait_timer #(
  parameter int TO_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stall,
  output logic o_expire
);

  localparam int              LIM   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TO_W-1:0] LIM_V = LIM[TO_W-1:0];

  logic [TO_W-1:0] r_cnt;

  assign o_expire = (TIMEOUT != 0) && i_stall && (r_cnt == LIM_V);

  always_ff @(posedge i_clk) begin
    if (i_rst)                     r_cnt <= '0;
    else if (!i_stall || o_expire) r_cnt <= '0;
    else if (r_cnt != '1)          r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Registered control sequencer for the accumulator CISC core.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_op[OP_W]              opcode from IR, stable DECODE..next FETCH
//   i_zero                  accumulator == 0
//   i_mem_ready             memory completes the current rd/wr this cycle
//   i_run                   restart request, only honoured in HALT
//   o_ld_ir..o_dout_en      datapath strobes (combinational)
//   o_state                 current state code
//   o_halted                1 while in HALT
//   o_bus_err, o_illegal_op sticky fault flags, cleared by reset or restart
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int TO_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_zero,
  input  logic            i_mem_ready,
  input  logic            i_run,
  output logic            o_ld_ir,
  output logic            o_ld_mdr,
  output logic            o_ld_acc,
  output logic            o_ld_pc,
  output logic            o_inc,
  output logic            o_sel,
  output logic            o_rd,
  output logic            o_wr,
  output logic            o_dout_en,
  output logic [2:0]      o_state,
  output logic            o_halted,
  output logic            o_bus_err,
  output logic            o_illegal_op
);

  state_t   r_state;
  logic     r_bus_err;
  logic     r_illegal;

  state_t   w_next;
  strobes_t w_strb;
  logic     w_set_bus_err;
  logic     w_set_illegal;
  logic     w_clr_flags;
  logic     w_wait;
  logic     w_stall;
  logic     w_expire;
  logic     w_legal;
  logic [2:0] w_op3;

  // Anything with a bit set above the low three is outside the opcode map.
  assign w_legal = ((i_op >> 3) == '0);
  assign w_op3   = i_op[2:0];

  // States where a memory access is pending; kept apart from the main decode
  // so the timer's expire does not feed back into its own stall input.
  assign w_wait  = (r_state == ST_FETCH) ||
                   ((r_state == ST_EXEC1) && w_legal &&
                    (is_mem_rd_op(w_op3) || (w_op3 == OP_STO)));
  assign w_stall = w_wait && !i_mem_ready;

  cpu_sequencer_wait_timer #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_stall  (w_stall),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_RESET;
      r_bus_err <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clr_flags) begin
        r_bus_err <= 1'b0;
        r_illegal <= 1'b0;
      end else begin
        if (w_set_bus_err) r_bus_err <= 1'b1;
        if (w_set_illegal) r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_strb        = '0;
    w_set_bus_err = 1'b0;
    w_set_illegal = 1'b0;
    w_clr_flags   = 1'b0;
    case (r_state)
      ST_RESET:  w_next = ST_FETCH;
      ST_FETCH: begin
        if (i_mem_ready) begin
          w_strb.rd    = 1'b1;
          w_strb.ld_ir = 1'b1;
          w_next       = ST_DECODE;
        end else if (w_expire) begin
          w_set_bus_err = 1'b1;
          w_next        = ST_HALT;
        end else begin
          w_strb.rd = 1'b1;
        end
      end
      ST_DECODE: w_next = ST_EXEC1;
      ST_EXEC1: begin
        if (!w_legal) begin
          w_set_illegal = 1'b1;
          w_next        = ST_HALT;
        end else begin
          case (w_op3)
            OP_HLT: begin
              w_strb.sel = 1'b1;
              w_next     = ST_HALT;
            end
            OP_SKZ: begin
              w_strb.sel = 1'b1;
              w_strb.inc = 1'b1;
              w_next     = ST_EXEC2;
            end
            OP_STO: begin
              if (i_mem_ready) begin
                w_strb.wr      = 1'b1;
                w_strb.dout_en = 1'b1;
                w_strb.sel     = 1'b1;
                w_strb.inc     = 1'b1;
                w_next         = ST_FETCH;
              end else if (w_expire) begin
                w_set_bus_err = 1'b1;
                w_next        = ST_HALT;
              end else begin
                w_strb.wr      = 1'b1;
                w_strb.dout_en = 1'b1;
                w_strb.sel     = 1'b1;
              end
            end
            OP_JMP: begin
              w_strb.ld_pc = 1'b1;
              w_next       = ST_FETCH;
            end
            default: begin  // ADD/AND/XOR/LOAD
              if (i_mem_ready) begin
                w_strb.rd     = 1'b1;
                w_strb.sel    = 1'b1;
                w_strb.ld_mdr = 1'b1;
                w_strb.inc    = 1'b1;
                w_next        = ST_EXEC2;
              end else if (w_expire) begin
                w_set_bus_err = 1'b1;
                w_next        = ST_HALT;
              end else begin
                w_strb.rd  = 1'b1;
                w_strb.sel = 1'b1;
              end
            end
          endcase
        end
      end
      ST_EXEC2: begin
        if (w_op3 == OP_SKZ)      w_strb.inc    = i_zero;
        else if (is_mem_rd_op(w_op3)) w_strb.ld_acc = 1'b1;
        w_next = ST_FETCH;
      end
      ST_HALT: begin
        if (i_run) begin
          w_clr_flags = 1'b1;
          w_next      = ST_FETCH;
        end
      end
      default: w_next = ST_RESET;
    endcase
  end

  // Reset overrides the decode so a mid-access reset emits no strobe pulse.
  assign o_ld_ir      = w_strb.ld_ir   && !i_rst;
  assign o_ld_mdr     = w_strb.ld_mdr  && !i_rst;
  assign o_ld_acc     = w_strb.ld_acc  && !i_rst;
  assign o_ld_pc      = w_strb.ld_pc   && !i_rst;
  assign o_inc        = w_strb.inc     && !i_rst;
  assign o_sel        = w_strb.sel     && !i_rst;
  assign o_rd         = w_strb.rd      && !i_rst;
  assign o_wr         = w_strb.wr      && !i_rst;
  assign o_dout_en    = w_strb.dout_en && !i_rst;
  assign o_state      = r_state;
  assign o_halted     = (r_state == ST_HALT) && !i_rst;
  assign o_bus_err    = r_bus_err;
  assign o_illegal_op = r_illegal;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam logic [2:0] S_FE = 3'b000, S_DE = 3'b001, S_E1 = 3'b010,
                         S_E2 = 3'b011, S_RS = 3'b100, S_HL = 3'b101;
  // strobe vector order: ld_ir ld_mdr ld_acc ld_pc inc sel rd wr dout_en
  localparam logic [8:0] LD_IR = 9'h100, LD_MDR = 9'h080, LD_ACC = 9'h040,
                         LD_PC = 9'h020, INC = 9'h010, SEL = 9'h008,
                         RD = 9'h004, WR = 9'h002, DEN = 9'h001, NONE = 9'h000;

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic       zero;
    logic       mr;
    logic       run;
    logic       tgt;
    logic [2:0] st;
    logic [8:0] sb;
    logic [2:0] fl;   // halted, bus_err, illegal_op
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, zero0 = 1'b0, mr0 = 1'b0, run0 = 1'b0;
  logic [2:0] op0 = 3'd0;
  logic       rst1 = 1'b1, zero1 = 1'b0, mr1 = 1'b0, run1 = 1'b0;
  logic [3:0] op1 = 4'd0;

  logic [8:0] sb0, sb1;
  logic [2:0] st0, st1;
  logic       h0, be0, il0, h1, be1, il1;

  cpu_sequencer #(.OP_W(3), .TO_W(4), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst(rst0), .i_op(op0), .i_zero(zero0),
    .i_mem_ready(mr0), .i_run(run0),
    .o_ld_ir(sb0[8]), .o_ld_mdr(sb0[7]), .o_ld_acc(sb0[6]), .o_ld_pc(sb0[5]),
    .o_inc(sb0[4]), .o_sel(sb0[3]), .o_rd(sb0[2]), .o_wr(sb0[1]),
    .o_dout_en(sb0[0]), .o_state(st0), .o_halted(h0), .o_bus_err(be0),
    .o_illegal_op(il0)
  );

  cpu_sequencer #(.OP_W(4), .TO_W(4), .TIMEOUT(15)) dut4 (
    .i_clk(clk), .i_rst(rst1), .i_op(op1), .i_zero(zero1),
    .i_mem_ready(mr1), .i_run(run1),
    .o_ld_ir(sb1[8]), .o_ld_mdr(sb1[7]), .o_ld_acc(sb1[6]), .o_ld_pc(sb1[5]),
    .o_inc(sb1[4]), .o_sel(sb1[3]), .o_rd(sb1[2]), .o_wr(sb1[1]),
    .o_dout_en(sb1[0]), .o_state(st1), .o_halted(h1), .o_bus_err(be1),
    .o_illegal_op(il1)
  );

  int checks = 0;
  int errors = 0;
  int popped = 0;

  task automatic v(input logic r, input logic [3:0] op, input logic z,
                   input logic mr, input logic run, input logic t,
                   input logic [2:0] st, input logic [8:0] sb, input logic [2:0] fl);
    vec_t e;
    e.rst = r; e.op = op; e.zero = z; e.mr = mr; e.run = run; e.tgt = t;
    e.st = st; e.sb = sb; e.fl = fl;
    vecs.push_back(e);
  endtask

  // Monitor: compare every cycle the DUT presents against the next expectation.
  always @(negedge clk) begin
    if (expq.size() != 0) begin
      vec_t e;
      logic [2:0] ast, afl;
      logic [8:0] asb;
      e = expq.pop_front();
      popped++;
      ast = e.tgt ? st1 : st0;
      asb = e.tgt ? sb1 : sb0;
      afl = e.tgt ? {h1, be1, il1} : {h0, be0, il0};
      checks++;
      if (ast !== e.st) begin
        errors++;
        $display("FAIL state vec%0d dut%0d: got %b want %b", popped, e.tgt, ast, e.st);
      end
      checks++;
      if (asb !== e.sb) begin
        errors++;
        $display("FAIL strobes vec%0d dut%0d: got %b want %b", popped, e.tgt, asb, e.sb);
      end
      checks++;
      if (afl !== e.fl) begin
        errors++;
        $display("FAIL flags vec%0d dut%0d: got %b want %b", popped, e.tgt, afl, e.fl);
      end
    end
  end

  initial begin
    int nv;
    // reset, then ADD with three wait states
    v(1, 2, 0, 1, 0, 0, S_RS, NONE, 3'b000);
    v(1, 2, 0, 1, 0, 0, S_RS, NONE, 3'b000);
    v(0, 2, 0, 1, 0, 0, S_RS, NONE, 3'b000);
    v(0, 2, 0, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    v(0, 2, 0, 1, 0, 0, S_DE, NONE, 3'b000);
    for (int i = 0; i < 3; i++) v(0, 2, 0, 0, 0, 0, S_E1, RD | SEL, 3'b000);
    v(0, 2, 0, 1, 0, 0, S_E1, LD_MDR | INC | SEL | RD, 3'b000);
    v(0, 2, 0, 1, 0, 0, S_E2, LD_ACC, 3'b000);
    // SKZ, zero=1: two incs
    v(0, 1, 1, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    v(0, 1, 1, 1, 0, 0, S_DE, NONE, 3'b000);
    v(0, 1, 1, 1, 0, 0, S_E1, SEL | INC, 3'b000);
    v(0, 1, 1, 1, 0, 0, S_E2, INC, 3'b000);
    // SKZ, zero=0: one inc
    v(0, 1, 0, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    v(0, 1, 0, 1, 0, 0, S_DE, NONE, 3'b000);
    v(0, 1, 0, 1, 0, 0, S_E1, SEL | INC, 3'b000);
    v(0, 1, 0, 1, 0, 0, S_E2, NONE, 3'b000);
    // XOR zero-wait
    v(0, 4, 0, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    v(0, 4, 0, 1, 0, 0, S_DE, NONE, 3'b000);
    v(0, 4, 0, 1, 0, 0, S_E1, LD_MDR | INC | SEL | RD, 3'b000);
    v(0, 4, 0, 1, 0, 0, S_E2, LD_ACC, 3'b000);
    // FETCH: ready arrives exactly in the would-be timeout cycle
    for (int i = 0; i < 14; i++) v(0, 6, 0, 0, 0, 0, S_FE, RD, 3'b000);
    v(0, 6, 0, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    v(0, 6, 0, 0, 0, 0, S_DE, NONE, 3'b000);
    // STORE never ready: 14 held stall cycles, 15th expires
    for (int i = 0; i < 14; i++) v(0, 6, 0, 0, 0, 0, S_E1, WR | DEN | SEL, 3'b000);
    v(0, 6, 0, 0, 0, 0, S_E1, NONE, 3'b000);
    v(0, 6, 0, 0, 1, 0, S_HL, NONE, 3'b110);
    v(0, 6, 0, 0, 0, 0, S_FE, RD, 3'b000);
    // JUMP
    v(0, 7, 0, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    v(0, 7, 0, 1, 0, 0, S_DE, NONE, 3'b000);
    v(0, 7, 0, 1, 0, 0, S_E1, LD_PC, 3'b000);
    // STORE zero-wait
    v(0, 6, 0, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    v(0, 6, 0, 1, 0, 0, S_DE, NONE, 3'b000);
    v(0, 6, 0, 1, 0, 0, S_E1, WR | DEN | SEL | INC, 3'b000);
    // HALT, run ignored until asserted
    v(0, 0, 0, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    v(0, 0, 0, 1, 1, 0, S_DE, NONE, 3'b000);
    v(0, 0, 0, 1, 1, 0, S_E1, SEL, 3'b000);
    v(0, 0, 0, 1, 0, 0, S_HL, NONE, 3'b100);
    v(0, 0, 0, 1, 0, 0, S_HL, NONE, 3'b100);
    v(0, 0, 0, 1, 1, 0, S_HL, NONE, 3'b100);
    // reset mid-stall in EXEC1
    v(0, 2, 0, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    v(0, 2, 0, 0, 0, 0, S_DE, NONE, 3'b000);
    v(0, 2, 0, 0, 0, 0, S_E1, RD | SEL, 3'b000);
    v(1, 2, 0, 1, 0, 0, S_E1, NONE, 3'b000);
    v(0, 2, 0, 1, 0, 0, S_RS, NONE, 3'b000);
    v(0, 2, 0, 1, 0, 0, S_FE, LD_IR | RD, 3'b000);
    // OP_W=4 instance: illegal opcode trap
    v(1, 4'b1010, 0, 1, 0, 1, S_RS, NONE, 3'b000);
    v(0, 4'b1010, 0, 1, 0, 1, S_RS, NONE, 3'b000);
    v(0, 4'b1010, 0, 1, 0, 1, S_FE, LD_IR | RD, 3'b000);
    v(0, 4'b1010, 0, 1, 0, 1, S_DE, NONE, 3'b000);
    v(0, 4'b1010, 0, 1, 0, 1, S_E1, NONE, 3'b000);
    for (int i = 0; i < 10; i++) v(0, 4'b1010, 0, 1, 0, 1, S_HL, NONE, 3'b101);
    v(0, 4'b1010, 0, 1, 1, 1, S_HL, NONE, 3'b101);
    v(0, 4'b0111, 0, 1, 0, 1, S_FE, LD_IR | RD, 3'b000);
    v(0, 4'b0111, 0, 1, 0, 1, S_DE, NONE, 3'b000);
    v(0, 4'b0111, 0, 1, 0, 1, S_E1, LD_PC, 3'b000);
    v(0, 4'b0111, 0, 0, 0, 1, S_FE, RD, 3'b000);

    nv = vecs.size();
    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      if (vecs[k].tgt == 1'b0) begin
        rst0 = vecs[k].rst; op0 = vecs[k].op[2:0]; zero0 = vecs[k].zero;
        mr0 = vecs[k].mr; run0 = vecs[k].run;
        rst1 = 1'b1;
      end else begin
        rst1 = vecs[k].rst; op1 = vecs[k].op; zero1 = vecs[k].zero;
        mr1 = vecs[k].mr; run1 = vecs[k].run;
        rst0 = 1'b1;
      end
      expq.push_back(vecs[k]);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (popped != nv) begin
      errors++;
      $display("FAIL drain: got %0d compared want %0d", popped, nv);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
